// File: rtl/switch_input_ctrl_pkg.sv
// Shared register map for the switch/button input peripheral.
// Offsets are relative to the peripheral base address.
package switch_pkg;

  localparam logic [31:0] OFS_BTN_STICKY = 32'h0000_0000;
  localparam logic [31:0] OFS_BTN_LEVEL  = 32'h0000_0004;
  localparam logic [31:0] OFS_SW_FULL    = 32'h0000_0010;
  localparam logic [31:0] OFS_SW_HI      = 32'h0000_0014;
  localparam logic [31:0] OFS_SW_LO_S    = 32'h0000_0018;
  localparam logic [31:0] OFS_SW_LO_U    = 32'h0000_001C;
  localparam logic [31:0] OFS_SW_LO3     = 32'h0000_0020;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [31:0] ofs);
    return base + ofs;
  endfunction

endpackage

// File: rtl/switch_input_ctrl_if.sv
// CPU-side read bus of the switch/button peripheral: decoder select,
// byte address and registered read data.
interface switch_input_ctrl_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  switchCtrl;
  logic [31:0]           address;
  logic [DATA_WIDTH-1:0] dataIOInput;

  modport master (output switchCtrl, output address, input dataIOInput);
  modport slave  (input switchCtrl, input address, output dataIOInput);

endinterface

// File: rtl/switch_input_ctrl_btn_debounce.sv
// Per-button debouncer: accepts a new level only after it has been seen
// for DEBOUNCE_CYCLES consecutive cycles; flags stable 0->1 transitions.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic          stable_reg, stable_next;

  // Any agreeing cycle restarts the count, so only an unbroken run flips.
  always_comb begin
    cnt_next    = '0;
    stable_next = stable_reg;
    rise        = 1'b0;
    if (raw != stable_reg) begin
      if (cnt_reg == CNT_LAST) begin
        stable_next = ~stable_reg;
        rise        = ~stable_reg;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
    end
  end

  assign stable = stable_reg;

endmodule

// File: rtl/switch_input_ctrl.sv
// Memory-mapped switch/button input peripheral: sync, debounce, sticky
// press capture with clear-on-read. Optional btnIrq under SW_BTN_IRQ_EN.
module switch_input_ctrl
  import switch_pkg::*;
#(
  parameter int          SW_WIDTH        = 16,
  parameter int          BTN_COUNT       = 4,
  parameter int          DATA_WIDTH      = 32,
  parameter int          DEBOUNCE_CYCLES = 20000,
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FF00
) (
  input  logic                 clk,
  input  logic                 rst,
  switch_input_ctrl_if.slave   bus,
  input  logic [SW_WIDTH-1:0]  switchInput,
  input  logic [BTN_COUNT-1:0] buttonInput
`ifdef SW_BTN_IRQ_EN
  ,
  output logic                 btnIrq
`endif
);

  logic [SW_WIDTH-1:0]   sw_meta_reg, sw_sync_reg;
  logic [BTN_COUNT-1:0]  btn_meta_reg, btn_sync_reg;
  logic [BTN_COUNT-1:0]  btn_stable, btn_rise;
  logic [BTN_COUNT-1:0]  sticky_reg, sticky_next;
  logic [DATA_WIDTH-1:0] data_reg, rd_data;
  logic [15:0]           sw_lo16;
  logic                  rd_sticky;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
      btn_meta_reg <= '0;
      btn_sync_reg <= '0;
    end else begin
      sw_meta_reg  <= switchInput;
      sw_sync_reg  <= sw_meta_reg;
      btn_meta_reg <= buttonInput;
      btn_sync_reg <= btn_meta_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BTN_COUNT; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_sync_reg[gi]),
        .stable(btn_stable[gi]),
        .rise  (btn_rise[gi])
      );
    end

    // Byte-lane views see absent upper switches as 0 on narrow builds.
    if (SW_WIDTH >= 16) begin : g_sw_wide
      assign sw_lo16 = sw_sync_reg[15:0];
    end else begin : g_sw_narrow
      assign sw_lo16 = {{(16 - SW_WIDTH){1'b0}}, sw_sync_reg};
    end
  endgenerate

  assign rd_sticky = bus.switchCtrl && (bus.address == reg_addr(BASE_ADDR, OFS_BTN_STICKY));

  // A press landing on the clearing read survives: set beats clear.
  always_comb begin
    sticky_next = (rd_sticky ? '0 : sticky_reg) | btn_rise;
  end

  always_comb begin
    rd_data = '0;
    case (bus.address)
      reg_addr(BASE_ADDR, OFS_BTN_STICKY): rd_data[BTN_COUNT-1:0] = sticky_reg;
      reg_addr(BASE_ADDR, OFS_BTN_LEVEL):  rd_data[BTN_COUNT-1:0] = btn_stable;
      reg_addr(BASE_ADDR, OFS_SW_FULL):    rd_data[SW_WIDTH-1:0]  = sw_sync_reg;
      reg_addr(BASE_ADDR, OFS_SW_HI):      rd_data[7:0]           = sw_lo16[15:8];
      reg_addr(BASE_ADDR, OFS_SW_LO_S): begin
        rd_data      = {DATA_WIDTH{sw_lo16[7]}};
        rd_data[7:0] = sw_lo16[7:0];
      end
      reg_addr(BASE_ADDR, OFS_SW_LO_U):    rd_data[7:0]           = sw_lo16[7:0];
      reg_addr(BASE_ADDR, OFS_SW_LO3):     rd_data[2:0]           = sw_lo16[2:0];
      default:                             rd_data                = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_reg <= '0;
      data_reg   <= '0;
    end else begin
      sticky_reg <= sticky_next;
      data_reg   <= bus.switchCtrl ? rd_data : '0;
    end
  end

  assign bus.dataIOInput = data_reg;

`ifdef SW_BTN_IRQ_EN
  logic irq_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= |sticky_reg;
    end
  end

  assign btnIrq = irq_reg;
`endif

endmodule

// File: doc/switch_input_ctrl.md
Name: switch_input_ctrl

Overview:
- Parametrised memory-mapped input peripheral for board switches and push-buttons.
- Synchronises all inputs, debounces buttons, and latches sticky press events that are cleared on read.
- Returns registered, width-formatted read data to the CPU data-IO path.
- Sits on the IO bus beside the LED/seg-display peripherals; selected by the decoder via switchCtrl.

Parameters:
- SW_WIDTH, 16, number of slide switches (8..32).
- BTN_COUNT, 4, number of push-buttons (1..16).
- DATA_WIDTH, 32, width of read data returned to CPU (>= SW_WIDTH, >= BTN_COUNT).
- DEBOUNCE_CYCLES, 20000, stable cycles required before a button level is accepted (>= 2).
- BASE_ADDR, 32'hFFFF_FF00, base of the register window.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- switchCtrl  input  1  read select from the IO decoder; one read per asserted cycle.
- address  input  32  CPU byte address.
- switchInput  input  SW_WIDTH  raw switch levels, asynchronous.
- buttonInput  input  BTN_COUNT  raw button levels, active-high, asynchronous, bouncing.
- dataIOInput  output  DATA_WIDTH  registered read data.
- btnIrq  output  1  press-pending interrupt (present only with SW_BTN_IRQ_EN).

Behaviour:
- Reset (rst low, async): dataIOInput=0, sync flops=0, debounce counters=0, stable levels=0, sticky=0, btnIrq=0.
- Sync: every switch and button bit passes through 2 flops. Switches are not debounced.
- Debounce, per button:
  - If synced level != stable level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 on a mismatching cycle, the stable level flips and the counter clears.
  - Any cycle with synced == stable clears the counter.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - Raw edge to stable flip = 2 + DEBOUNCE_CYCLES cycles for a clean input.
- Press event: a stable 0->1 transition sets sticky[i] in the same cycle as the flip. Release sets nothing.
- Register map (offsets from BASE_ADDR; the full 32-bit address must match exactly):
  - 0x00 sticky presses, zero-extended; read clears.
  - 0x04 stable button levels, zero-extended.
  - 0x10 switches, zero-extended.
  - 0x14 switches[15:8], zero-extended.
  - 0x18 switches[7:0], sign-extended from bit 7.
  - 0x1C switches[7:0], zero-extended.
  - 0x20 switches[2:0], zero-extended.
  - Any other address with switchCtrl=1 returns 0.
- Read timing: when switchCtrl=1 at edge N, dataIOInput holds the value at edge N. When switchCtrl=0, dataIOInput is 0 at the next edge. Latency is 1 cycle.
- Read-clear: a read of 0x00 clears all sticky bits returned. A press setting sticky[i] in the same cycle wins: that bit stays 1 and is not included in the returned value. Set has priority over clear.
- Back-to-back reads of 0x00: the second read returns only presses latched after the first.
- Reset mid-debounce drops all partial counts. A button held through reset release produces a press after 2 + DEBOUNCE_CYCLES cycles.
- Byte-lane offsets 0x14/0x18 with SW_WIDTH < 16: missing bits read 0.

Optional Feature:
- Macro SW_BTN_IRQ_EN.
- Defined: port btnIrq exists and is registered; btnIrq = OR of sticky bits, 1-cycle lag. It deasserts the cycle after a clearing read unless a new press is pending.
- Undefined: btnIrq port and logic are absent; software polls offset 0x00.

Decomposition:
- Shared package switch_pkg: register offset localparams (OFS_BTN_STICKY, OFS_BTN_LEVEL, OFS_SW_FULL, OFS_SW_HI, OFS_SW_LO_S, OFS_SW_LO_U, OFS_SW_LO3).
- Sub-module btn_debounce, one per button via generate. Parameter DEBOUNCE_CYCLES; I/O clk, rst, raw, stable, rise.
- Synchroniser, sticky logic and read mux live in the top.

Test Plan (DEBOUNCE_CYCLES=4, BASE_ADDR=32'hFFFF_FF00):
- Reset, then switchInput=16'hA5C3, read 0xFFFF_FF10 / 14 / 18 / 1C / 20 -> 32'h0000A5C3, 32'h000000A5, 32'hFFFFFFC3, 32'h000000C3, 32'h00000003, each 1 cycle after the select edge.
- buttonInput[1] toggles 0/1 every 2 cycles for 20 cycles, then holds 1 -> no flip during bounce; stable[1]=1 exactly 6 cycles after the last edge; read 0x00 -> 32'h2.
- Read 0x00 twice with no new press -> 32'h2 then 32'h0; btnIrq (SW_BTN_IRQ_EN) falls 1 cycle after the first read.
- Press event on button 0 in the same cycle as a read of 0x00 with sticky=4'b0100 -> returns 32'h4; sticky becomes 4'b0001.
- Read unmapped address 0xFFFF_FF08, and any cycle with switchCtrl=0 -> dataIOInput=0.
- Assert rst low mid-count with button held -> all outputs 0 immediately; after release, press latched at cycle 6; read 0x04 -> 32'h1.
